// File: rtl/fsm_3l_anpc.sv
// -----------------------------------------------------------------------------
// fsm_3l_anpc
// Gate-pattern sequencer for one leg of a 3L-ANPC converter. Turns a requested
// output level (v_lev) and a commutation strategy (comm_type) into the six
// switch gates S_out. It inserts the timed intermediate vectors that each
// strategy needs between stable levels.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-low reset
//   t_short      short overlap step (cycles)
//   t_off_on     turn-off to turn-on dead-time (cycles)
//   t_on_offV0   type_II entry delay into full zero (cycles)
//   t_offV0_on   type_II exit delay from full zero (cycles)
//   t_off_onI0   type_III exit delay from lower zero (cycles)
//   v_lev        requested level: 00=O, 01=P, 10=N, 11=O
//   comm_type    commutation strategy (type_I / type_II / type_III)
//   S_out        registered gates, S_out[k-1] = Sk
//
// Optional build macro FSM_3L_ANPC_DEBUG_EN adds the observation ports
// state, next_state, old_state, transition, finish_transition and counter.
// S_out timing is the same with or without it.
// -----------------------------------------------------------------------------

package PKG_decoder_3lxnpc;
  typedef enum logic [1:0] {
    type_I   = 2'd0,
    type_II  = 2'd1,
    type_III = 2'd2
  } _commtypes_t;
endpackage

module fsm_3l_anpc
  import PKG_decoder_3lxnpc::*;
#(
  parameter int unsigned TDELAY_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [TDELAY_WIDTH-1:0] t_short,
  input  logic [TDELAY_WIDTH-1:0] t_off_on,
  input  logic [TDELAY_WIDTH-1:0] t_on_offV0,
  input  logic [TDELAY_WIDTH-1:0] t_offV0_on,
  input  logic [TDELAY_WIDTH-1:0] t_off_onI0,
  input  logic [1:0]              v_lev,
  input  _commtypes_t             comm_type,
  output logic [5:0]              S_out
`ifdef FSM_3L_ANPC_DEBUG_EN
 ,output logic [2:0]              state
 ,output logic [2:0]              next_state
 ,output logic [2:0]              old_state
 ,output logic                    transition
 ,output logic                    finish_transition
 ,output logic [TDELAY_WIDTH-1:0] counter
`endif
);

  localparam int unsigned CW = TDELAY_WIDTH;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // Stable gate vectors
  localparam logic [5:0] VEC_P  = 6'h23;
  localparam logic [5:0] VEC_N  = 6'h1C;
  localparam logic [5:0] VEC_OU = 6'h12;
  localparam logic [5:0] VEC_OL = 6'h24;
  localparam logic [5:0] VEC_O2 = 6'h36;

  // Intermediate gate vectors
  localparam logic [5:0] VEC_02 = 6'h02;
  localparam logic [5:0] VEC_10 = 6'h10;
  localparam logic [5:0] VEC_22 = 6'h22;
  localparam logic [5:0] VEC_14 = 6'h14;
  localparam logic [5:0] VEC_26 = 6'h26;
  localparam logic [5:0] VEC_04 = 6'h04;

  typedef enum logic [2:0] {
    LEV_OFF = 3'd0,
    LEV_P   = 3'd1,
    LEV_N   = 3'd2,
    LEV_OU  = 3'd3,
    LEV_OL  = 3'd4,
    LEV_O2  = 3'd5
  } lev_t;

  typedef enum logic [2:0] {
    D_SHORT    = 3'd0,
    D_OFF_ON   = 3'd1,
    D_ON_OFFV0 = 3'd2,
    D_OFFV0_ON = 3'd3,
    D_OFF_ONI0 = 3'd4
  } dsel_t;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_STABLE = 2'd1,
    ST_STEP1  = 2'd2,
    ST_STEP2  = 2'd3
  } state_t;

  // Gate vector shown while stable in a level
  function automatic logic [5:0] lev_vec(input lev_t l);
    case (l)
      LEV_P:   lev_vec = VEC_P;
      LEV_N:   lev_vec = VEC_N;
      LEV_OU:  lev_vec = VEC_OU;
      LEV_OL:  lev_vec = VEC_OL;
      LEV_O2:  lev_vec = VEC_O2;
      default: lev_vec = 6'h00;
    endcase
  endfunction

  // Zero vector owned by each commutation type
  function automatic lev_t zero_of(input _commtypes_t t);
    case (t)
      type_II:  zero_of = LEV_O2;
      type_III: zero_of = LEV_OL;
      default:  zero_of = LEV_OU;
    endcase
  endfunction

  state_t          state_q;
  lev_t            lev_q;
  lev_t            old_lev_q;
  lev_t            tgt_q;
  logic [5:0]      s_out_q;
  logic [CW-1:0]   cnt_q;
  logic            has2_q;
  logic [5:0]      v2_q;
  dsel_t           d2_q;

  lev_t            zero_req_d;
  lev_t            tgt_d;
  logic            change_d;
  logic [5:0]      v1_d;
  dsel_t           sel1_d;
  logic            has2_d;
  logic [5:0]      v2_d;
  dsel_t           sel2_d;
  logic [CW-1:0]   raw1_d;
  logic [CW-1:0]   raw2_d;
  logic [CW-1:0]   cnt1_d;
  logic [CW-1:0]   cnt2_d;

  // Target level from the current stable level and the sampled request
  always_comb begin
    zero_req_d = zero_of(comm_type);
    tgt_d      = lev_q;
    case (v_lev)
      2'b01: begin
        if (lev_q == LEV_N)      tgt_d = zero_req_d;
        else if (lev_q != LEV_P) tgt_d = LEV_P;
      end
      2'b10: begin
        if (lev_q == LEV_P)      tgt_d = zero_req_d;
        else if (lev_q != LEV_N) tgt_d = LEV_N;
      end
      default: begin
        // P/N always drop into the requested zero; a zero realigns if it differs
        if (lev_q != zero_req_d) tgt_d = zero_req_d;
      end
    endcase
    change_d = (tgt_d != lev_q);
  end

  // Intermediate step table; leaving a zero follows the zero's own type
  always_comb begin
    v1_d   = 6'h00;
    sel1_d = D_SHORT;
    has2_d = 1'b0;
    v2_d   = 6'h00;
    sel2_d = D_SHORT;
    case (lev_q)
      LEV_P: begin
        case (tgt_d)
          LEV_OU: begin v1_d = VEC_02; sel1_d = D_OFF_ON; end
          LEV_O2: begin v1_d = VEC_22; sel1_d = D_ON_OFFV0; end
          LEV_OL: begin
            v1_d = VEC_22; sel1_d = D_OFF_ON;
            has2_d = 1'b1; v2_d = VEC_26; sel2_d = D_SHORT;
          end
          default: ;
        endcase
      end
      LEV_N: begin
        case (tgt_d)
          LEV_OU: begin v1_d = VEC_10; sel1_d = D_OFF_ON; end
          LEV_O2: begin v1_d = VEC_14; sel1_d = D_ON_OFFV0; end
          LEV_OL: begin v1_d = VEC_04; sel1_d = D_OFF_ON; end
          default: ;
        endcase
      end
      LEV_OU: begin
        case (tgt_d)
          LEV_P:  begin v1_d = VEC_02; sel1_d = D_OFF_ON; end
          LEV_N:  begin v1_d = VEC_10; sel1_d = D_OFF_ON; end
          LEV_OL: begin v1_d = VEC_O2; sel1_d = D_SHORT; end
          LEV_O2: begin v1_d = VEC_OU; sel1_d = D_SHORT; end
          default: ;
        endcase
      end
      LEV_OL: begin
        case (tgt_d)
          LEV_P: begin
            v1_d = VEC_26; sel1_d = D_SHORT;
            has2_d = 1'b1; v2_d = VEC_22; sel2_d = D_OFF_ONI0;
          end
          LEV_N:  begin v1_d = VEC_04; sel1_d = D_OFF_ONI0; end
          LEV_OU: begin v1_d = VEC_O2; sel1_d = D_SHORT; end
          LEV_O2: begin v1_d = VEC_OL; sel1_d = D_SHORT; end
          default: ;
        endcase
      end
      LEV_O2: begin
        case (tgt_d)
          LEV_P:  begin v1_d = VEC_22; sel1_d = D_OFFV0_ON; end
          LEV_N:  begin v1_d = VEC_14; sel1_d = D_OFFV0_ON; end
          LEV_OU: begin v1_d = VEC_O2; sel1_d = D_SHORT; end
          LEV_OL: begin v1_d = VEC_O2; sel1_d = D_SHORT; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Delay select for the first step (sampled now) and the pending second step
  always_comb begin
    case (sel1_d)
      D_OFF_ON:   raw1_d = t_off_on;
      D_ON_OFFV0: raw1_d = t_on_offV0;
      D_OFFV0_ON: raw1_d = t_offV0_on;
      D_OFF_ONI0: raw1_d = t_off_onI0;
      default:    raw1_d = t_short;
    endcase
    case (d2_q)
      D_OFF_ON:   raw2_d = t_off_on;
      D_ON_OFFV0: raw2_d = t_on_offV0;
      D_OFFV0_ON: raw2_d = t_offV0_on;
      D_OFF_ONI0: raw2_d = t_off_onI0;
      default:    raw2_d = t_short;
    endcase
    // Counter holds remaining cycles minus one; a zero delay still lasts a cycle
    cnt1_d = (raw1_d == '0) ? '0 : raw1_d - CNT_ONE;
    cnt2_d = (raw2_d == '0) ? '0 : raw2_d - CNT_ONE;
  end

  // Sequencer state, level tracking and registered gate vector
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_OFF;
      lev_q     <= LEV_OFF;
      old_lev_q <= LEV_OFF;
      tgt_q     <= LEV_OFF;
      s_out_q   <= 6'h00;
      cnt_q     <= '0;
      has2_q    <= 1'b0;
      v2_q      <= 6'h00;
      d2_q      <= D_SHORT;
    end else begin
      case (state_q)
        ST_OFF: begin
          lev_q   <= zero_req_d;
          tgt_q   <= zero_req_d;
          s_out_q <= lev_vec(zero_req_d);
          state_q <= ST_STABLE;
        end
        ST_STABLE: begin
          if (change_d) begin
            tgt_q   <= tgt_d;
            s_out_q <= v1_d;
            cnt_q   <= cnt1_d;
            has2_q  <= has2_d;
            v2_q    <= v2_d;
            d2_q    <= sel2_d;
            state_q <= ST_STEP1;
          end
        end
        ST_STEP1: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else if (has2_q) begin
            s_out_q <= v2_q;
            cnt_q   <= cnt2_d;
            state_q <= ST_STEP2;
          end else begin
            s_out_q   <= lev_vec(tgt_q);
            old_lev_q <= lev_q;
            lev_q     <= tgt_q;
            state_q   <= ST_STABLE;
          end
        end
        default: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else begin
            s_out_q   <= lev_vec(tgt_q);
            old_lev_q <= lev_q;
            lev_q     <= tgt_q;
            state_q   <= ST_STABLE;
          end
        end
      endcase
    end
  end

  assign S_out = s_out_q;

`ifdef FSM_3L_ANPC_DEBUG_EN
  // Observation taps, decoded straight from the state registers
  assign state             = 3'(lev_q);
  assign next_state        = 3'(tgt_q);
  assign old_state         = 3'(old_lev_q);
  assign transition        = (state_q == ST_STEP1) || (state_q == ST_STEP2);
  assign finish_transition = (cnt_q == '0) &&
                             ((state_q == ST_STEP2) || ((state_q == ST_STEP1) && !has2_q));
  assign counter           = cnt_q;
`endif

endmodule

// File: tb/tb_fsm_3l_anpc.sv
// -----------------------------------------------------------------------------
// tb_fsm_3l_anpc
// Directed bench for fsm_3l_anpc: walks the commutation types through their
// level changes and checks S_out cycle by cycle against hand-derived vectors.
// Delays: t_short=3, t_off_on=10, t_on_offV0=7, t_offV0_on=6, t_off_onI0=9.
// -----------------------------------------------------------------------------
module tb_fsm_3l_anpc;
  import PKG_decoder_3lxnpc::*;

  localparam int unsigned TW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [TW-1:0] t_short, t_off_on, t_on_offV0, t_offV0_on, t_off_onI0;
  logic [1:0]    v_lev;
  _commtypes_t   comm_type;
  logic [5:0]    S_out;
`ifdef FSM_3L_ANPC_DEBUG_EN
  logic [2:0]    dbg_state, dbg_next, dbg_old;
  logic          dbg_trans, dbg_fin;
  logic [TW-1:0] dbg_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int inv_viol = 0;

  fsm_3l_anpc #(.TDELAY_WIDTH(TW)) dut (
    .clk        (clk),
    .rst        (rst),
    .t_short    (t_short),
    .t_off_on   (t_off_on),
    .t_on_offV0 (t_on_offV0),
    .t_offV0_on (t_offV0_on),
    .t_off_onI0 (t_off_onI0),
    .v_lev      (v_lev),
    .comm_type  (comm_type),
    .S_out      (S_out)
`ifdef FSM_3L_ANPC_DEBUG_EN
   ,.state             (dbg_state)
   ,.next_state        (dbg_next)
   ,.old_state         (dbg_old)
   ,.transition        (dbg_trans)
   ,.finish_transition (dbg_fin)
   ,.counter           (dbg_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Shoot-through watch: S1&S4, S1&S3, S2&S4, S1&S5
  always @(negedge clk) begin
    if ((S_out[0] && S_out[3]) || (S_out[0] && S_out[2]) ||
        (S_out[1] && S_out[3]) || (S_out[0] && S_out[4]))
      inv_viol++;
  end

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; comm_type = type_I; v_lev = 2'b00;
    t_short = 16'd3; t_off_on = 16'd10; t_on_offV0 = 16'd7;
    t_offV0_on = 16'd6; t_off_onI0 = 16'd9;
    repeat (3) tick();
    checks++; if (S_out !== 6'h00) begin errors++; $display("FAIL reset_hold: got %h want 00", S_out); end
    rst = 1'b1;
    tick();
    checks++; if (S_out !== 6'h12) begin errors++; $display("FAIL reset_release: got %h want 12", S_out); end
    tick();
    checks++; if (S_out !== 6'h12) begin errors++; $display("FAIL reset_stable: got %h want 12", S_out); end
  endtask

  task automatic test_type1();
    v_lev = 2'b01;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 1) t_off_on = 16'd2;  // mid-step change must not shorten the step
      checks++; if (S_out !== 6'h02) begin errors++; $display("FAIL t1_ou_p[%0d]: got %h want 02", i, S_out); end
    end
    t_off_on = 16'd10;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (S_out !== 6'h23) begin errors++; $display("FAIL t1_p_hold[%0d]: got %h want 23", i, S_out); end
    end
    v_lev = 2'b00;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (S_out !== 6'h02) begin errors++; $display("FAIL t1_p_ou[%0d]: got %h want 02", i, S_out); end
    end
    tick();
    checks++; if (S_out !== 6'h12) begin errors++; $display("FAIL t1_ou_end: got %h want 12", S_out); end
  endtask

  task automatic test_back_to_back();
    v_lev = 2'b01;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 2) v_lev = 2'b00;
      checks++; if (S_out !== 6'h02) begin errors++; $display("FAIL b2b_up[%0d]: got %h want 02", i, S_out); end
    end
    tick();
    checks++; if (S_out !== 6'h23) begin errors++; $display("FAIL b2b_p_one: got %h want 23", S_out); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (S_out !== 6'h02) begin errors++; $display("FAIL b2b_down[%0d]: got %h want 02", i, S_out); end
    end
    tick();
    checks++; if (S_out !== 6'h12) begin errors++; $display("FAIL b2b_end: got %h want 12", S_out); end
  endtask

  task automatic test_type2();
    comm_type = type_II;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (S_out !== 6'h12) begin errors++; $display("FAIL t2_align[%0d]: got %h want 12", i, S_out); end
    end
    tick();
    checks++; if (S_out !== 6'h36) begin errors++; $display("FAIL t2_o2: got %h want 36", S_out); end
    v_lev = 2'b01;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (S_out !== 6'h22) begin errors++; $display("FAIL t2_o2_p[%0d]: got %h want 22", i, S_out); end
    end
    tick();
    checks++; if (S_out !== 6'h23) begin errors++; $display("FAIL t2_p: got %h want 23", S_out); end
    v_lev = 2'b00;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++; if (S_out !== 6'h22) begin errors++; $display("FAIL t2_p_o2[%0d]: got %h want 22", i, S_out); end
    end
    tick();
    checks++; if (S_out !== 6'h36) begin errors++; $display("FAIL t2_back: got %h want 36", S_out); end
  endtask

  task automatic test_type3();
    comm_type = type_III;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (S_out !== 6'h36) begin errors++; $display("FAIL t3_align[%0d]: got %h want 36", i, S_out); end
    end
    tick();
    checks++; if (S_out !== 6'h24) begin errors++; $display("FAIL t3_ol: got %h want 24", S_out); end
    v_lev = 2'b10;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++; if (S_out !== 6'h04) begin errors++; $display("FAIL t3_ol_n[%0d]: got %h want 04", i, S_out); end
    end
    tick();
    checks++; if (S_out !== 6'h1C) begin errors++; $display("FAIL t3_n: got %h want 1C", S_out); end
    v_lev = 2'b00;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (S_out !== 6'h04) begin errors++; $display("FAIL t3_n_ol[%0d]: got %h want 04", i, S_out); end
    end
    tick();
    checks++; if (S_out !== 6'h24) begin errors++; $display("FAIL t3_ol2: got %h want 24", S_out); end
    v_lev = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (S_out !== 6'h26) begin errors++; $display("FAIL t3_ol_p_a[%0d]: got %h want 26", i, S_out); end
    end
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++; if (S_out !== 6'h22) begin errors++; $display("FAIL t3_ol_p_b[%0d]: got %h want 22", i, S_out); end
    end
    tick();
    checks++; if (S_out !== 6'h23) begin errors++; $display("FAIL t3_p: got %h want 23", S_out); end
  endtask

  task automatic test_realign();
    comm_type = type_I; v_lev = 2'b00;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (S_out !== 6'h02) begin errors++; $display("FAIL ra_p_ou[%0d]: got %h want 02", i, S_out); end
    end
    tick();
    checks++; if (S_out !== 6'h12) begin errors++; $display("FAIL ra_ou: got %h want 12", S_out); end
    comm_type = type_III;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (S_out !== 6'h36) begin errors++; $display("FAIL ra_mid[%0d]: got %h want 36", i, S_out); end
    end
    tick();
    checks++; if (S_out !== 6'h24) begin errors++; $display("FAIL ra_ol: got %h want 24", S_out); end
  endtask

  task automatic test_async_reset();
    v_lev = 2'b01;
    repeat (2) tick();
    checks++; if (S_out !== 6'h26) begin errors++; $display("FAIL ar_pre: got %h want 26", S_out); end
    #3 rst = 1'b0;
    #1;
    checks++; if (S_out !== 6'h00) begin errors++; $display("FAIL ar_async: got %h want 00", S_out); end
    comm_type = type_I; v_lev = 2'b00;
    tick();
    checks++; if (S_out !== 6'h00) begin errors++; $display("FAIL ar_held: got %h want 00", S_out); end
    rst = 1'b1;
    tick();
    checks++; if (S_out !== 6'h12) begin errors++; $display("FAIL ar_release: got %h want 12", S_out); end
  endtask

  task automatic test_zero_delay();
    t_off_on = 16'd0; v_lev = 2'b01;
    tick();
    checks++; if (S_out !== 6'h02) begin errors++; $display("FAIL zd_step: got %h want 02", S_out); end
    tick();
    checks++; if (S_out !== 6'h23) begin errors++; $display("FAIL zd_p: got %h want 23", S_out); end
    t_off_on = 16'd10;
  endtask

  task automatic test_p_to_n();
    v_lev = 2'b10;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (S_out !== 6'h02) begin errors++; $display("FAIL pn_a[%0d]: got %h want 02", i, S_out); end
    end
    tick();
    checks++; if (S_out !== 6'h12) begin errors++; $display("FAIL pn_zero: got %h want 12", S_out); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (S_out !== 6'h10) begin errors++; $display("FAIL pn_b[%0d]: got %h want 10", i, S_out); end
    end
    tick();
    checks++; if (S_out !== 6'h1C) begin errors++; $display("FAIL pn_n: got %h want 1C", S_out); end
  endtask

  task automatic test_invariant();
    checks++; if (inv_viol !== 0) begin errors++; $display("FAIL invariant: got %0d violations want 0", inv_viol); end
  endtask

  initial begin
    test_reset();
    test_type1();
    test_back_to_back();
    test_type2();
    test_type3();
    test_realign();
    test_async_reset();
    test_zero_delay();
    test_p_to_n();
    test_invariant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
